eth_frame_packer: RTL and testbench

ETH_FRAME_PACKER -- requirements
Module: eth_frame_packer

---
 rtl/eth_frame_packer.sv | 206 ++++++++++++++++++++
 tb/tb_eth_frame_packer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_packer.sv
// Ethernet frame packer: waits for a full payload in the upstream FIFO, then
// emits an application header followed by the payload bytes through a
// registered two-entry skid buffer, with a separate Ethernet header handshake.
module eth_frame_packer #(
  parameter int          PAYLOAD_LEN = 512,
  parameter int          HDR_LEN     = 20,
  parameter int          COUNT_WIDTH = 11,
  parameter logic [47:0] DEST_MAC    = 48'hD45D64A5F1A8,
  parameter logic [47:0] SRC_MAC     = 48'h020000000000,
  parameter logic [15:0] ETH_TYPE    = 16'h0800
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [7:0]             s_fifo_axis_tdata,
  input  logic                   s_fifo_axis_tvalid,
  output logic                   s_fifo_axis_tready,
  input  logic [COUNT_WIDTH-1:0] s_fifo_rd_data_count,
  output logic                   m_eth_hdr_valid,
  input  logic                   m_eth_hdr_ready,
  output logic [47:0]            m_eth_dest_mac,
  output logic [47:0]            m_eth_src_mac,
  output logic [15:0]            m_eth_type,
  output logic [7:0]             m_eth_payload_axis_tdata,
  output logic                   m_eth_payload_axis_tvalid,
  input  logic                   m_eth_payload_axis_tready,
  output logic                   m_eth_payload_axis_tlast,
  output logic                   m_eth_payload_axis_tuser,
  output logic                   busy,
  output logic [31:0]            frame_count
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, WAIT_HDR} state_t;

  localparam logic [COUNT_WIDTH-1:0] PL_CNT   = COUNT_WIDTH'(PAYLOAD_LEN);
  localparam logic [COUNT_WIDTH-1:0] PL_LAST  = COUNT_WIDTH'(PAYLOAD_LEN - 1);
  localparam logic [15:0]            PL16     = 16'(PAYLOAD_LEN);
  localparam logic [5:0]             HDR_LAST = 6'(HDR_LEN - 1);

  state_t                 state;
  logic [31:0]            seq_num;
  logic [31:0]            seq_latched;
  logic [5:0]             hdr_idx;
  logic [COUNT_WIDTH-1:0] pay_idx;
  logic                   pay_done;

  logic                   skid_valid;
  logic [7:0]             skid_data;
  logic                   skid_last;

  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_data;
  logic                   in_last;
  logic                   push;
  logic [7:0]             hdr_byte;
  logic                   out_fire;
  logic                   last_fire;
  logic                   hdr_fire;

  assign m_eth_dest_mac           = DEST_MAC;
  assign m_eth_src_mac            = SRC_MAC;
  assign m_eth_type               = ETH_TYPE;
  assign m_eth_payload_axis_tuser = 1'b0;

  // The skid buffer accepts new data whenever its spare slot is empty, so the
  // upstream ready depends only on registers, never on downstream ready.
  assign in_ready           = !skid_valid;
  assign s_fifo_axis_tready = (state == PAYLOAD) && !pay_done && !skid_valid;
  assign push               = in_valid && in_ready;
  assign out_fire           = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;
  assign last_fire          = out_fire && m_eth_payload_axis_tlast;
  assign hdr_fire           = m_eth_hdr_valid && m_eth_hdr_ready;
  assign busy               = (state != IDLE) || m_eth_payload_axis_tvalid || skid_valid;

  // Application header byte selected by the current header index.
  always_comb begin
    hdr_byte = {2'b00, hdr_idx};
    case (hdr_idx)
      6'd0: hdr_byte = seq_latched[31:24];
      6'd1: hdr_byte = seq_latched[23:16];
      6'd2: hdr_byte = seq_latched[15:8];
      6'd3: hdr_byte = seq_latched[7:0];
      6'd4: hdr_byte = PL16[15:8];
      6'd5: hdr_byte = PL16[7:0];
      default: hdr_byte = {2'b00, hdr_idx};
    endcase
  end

  // Source mux feeding the skid buffer: header bytes, then FIFO payload bytes.
  always_comb begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    case (state)
      HEADER: begin
        in_valid = 1'b1;
        in_data  = hdr_byte;
      end
      PAYLOAD: begin
        in_valid = s_fifo_axis_tvalid && s_fifo_axis_tready;
        in_data  = s_fifo_axis_tdata;
        in_last  = (pay_idx == PL_LAST);
      end
      default: begin
        in_valid = 1'b0;
      end
    endcase
  end

  // Frame sequencing: start, header/payload counting, completion and the
  // independent Ethernet header handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      m_eth_hdr_valid <= 1'b0;
      seq_num         <= 32'h0;
      seq_latched     <= 32'h0;
      frame_count     <= 32'h0;
      hdr_idx         <= 6'd0;
      pay_idx         <= '0;
      pay_done        <= 1'b0;
    end else begin
      if (hdr_fire) begin
        m_eth_hdr_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (enable && (s_fifo_rd_data_count >= PL_CNT)) begin
            state           <= HEADER;
            m_eth_hdr_valid <= 1'b1;
            seq_latched     <= seq_num;
            hdr_idx         <= 6'd0;
            pay_idx         <= '0;
            pay_done        <= 1'b0;
          end
        end
        HEADER: begin
          if (push) begin
            if (hdr_idx == HDR_LAST) begin
              state <= PAYLOAD;
            end else begin
              hdr_idx <= hdr_idx + 6'd1;
            end
          end
        end
        PAYLOAD: begin
          if (push) begin
            if (in_last) begin
              pay_done <= 1'b1;
            end else begin
              pay_idx <= pay_idx + 1'b1;
            end
          end
          if (last_fire) begin
            if (!m_eth_hdr_valid || hdr_fire) begin
              state       <= IDLE;
              seq_num     <= seq_num + 32'd1;
              frame_count <= frame_count + 32'd1;
            end else begin
              state <= WAIT_HDR;
            end
          end
        end
        WAIT_HDR: begin
          if (hdr_fire) begin
            state       <= IDLE;
            seq_num     <= seq_num + 32'd1;
            frame_count <= frame_count + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry skid buffer: the output register plus one spare slot that
  // catches the byte accepted in the cycle the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_eth_payload_axis_tvalid <= 1'b0;
      m_eth_payload_axis_tdata  <= 8'h00;
      m_eth_payload_axis_tlast  <= 1'b0;
      skid_valid                <= 1'b0;
      skid_data                 <= 8'h00;
      skid_last                 <= 1'b0;
    end else if (m_eth_payload_axis_tready || !m_eth_payload_axis_tvalid) begin
      if (skid_valid) begin
        m_eth_payload_axis_tvalid <= 1'b1;
        m_eth_payload_axis_tdata  <= skid_data;
        m_eth_payload_axis_tlast  <= skid_last;
        skid_valid                <= 1'b0;
        skid_last                 <= 1'b0;
      end else begin
        m_eth_payload_axis_tvalid <= push;
        m_eth_payload_axis_tdata  <= in_data;
        m_eth_payload_axis_tlast  <= push && in_last;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
      skid_last  <= in_last;
    end
  end

endmodule

// File: tb/tb_eth_frame_packer.sv
// Directed bench for eth_frame_packer with default parameters
// (512-byte payload, 20-byte header, 532-byte frames).
module tb_eth_frame_packer;

  localparam int FRAME_LEN = 532;
  localparam int HDR_LEN   = 20;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  s_fifo_axis_tdata;
  logic        s_fifo_axis_tvalid;
  logic        s_fifo_axis_tready;
  logic [10:0] s_fifo_rd_data_count;
  logic        m_eth_hdr_valid;
  logic        m_eth_hdr_ready;
  logic [47:0] m_eth_dest_mac;
  logic [47:0] m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [7:0]  m_eth_payload_axis_tdata;
  logic        m_eth_payload_axis_tvalid;
  logic        m_eth_payload_axis_tready;
  logic        m_eth_payload_axis_tlast;
  logic        m_eth_payload_axis_tuser;
  logic        busy;
  logic [31:0] frame_count;

  int          checks = 0;
  int          errors = 0;

  int          fifo_ptr = 0;
  int          pay_seen = 0;
  int          out_idx = 0;
  int          frames_seen = 0;
  int          gaps = 0;
  logic [31:0] exp_seq = 32'h0;
  logic        rnd_ready = 1'b0;
  logic        rnd_valid = 1'b0;
  logic        stall_prev = 1'b0;
  logic [7:0]  held_data = 8'h00;
  logic        held_last = 1'b0;

  eth_frame_packer dut (
    .clk                       (clk),
    .rst                       (rst),
    .enable                    (enable),
    .s_fifo_axis_tdata         (s_fifo_axis_tdata),
    .s_fifo_axis_tvalid        (s_fifo_axis_tvalid),
    .s_fifo_axis_tready        (s_fifo_axis_tready),
    .s_fifo_rd_data_count      (s_fifo_rd_data_count),
    .m_eth_hdr_valid           (m_eth_hdr_valid),
    .m_eth_hdr_ready           (m_eth_hdr_ready),
    .m_eth_dest_mac            (m_eth_dest_mac),
    .m_eth_src_mac             (m_eth_src_mac),
    .m_eth_type                (m_eth_type),
    .m_eth_payload_axis_tdata  (m_eth_payload_axis_tdata),
    .m_eth_payload_axis_tvalid (m_eth_payload_axis_tvalid),
    .m_eth_payload_axis_tready (m_eth_payload_axis_tready),
    .m_eth_payload_axis_tlast  (m_eth_payload_axis_tlast),
    .m_eth_payload_axis_tuser  (m_eth_payload_axis_tuser),
    .busy                      (busy),
    .frame_count               (frame_count)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] fifo_byte(int k);
    return 8'((k * 7 + 3) % 256);
  endfunction

  function automatic logic [7:0] hdr_exp(logic [31:0] s, int idx);
    case (idx)
      0: return s[31:24];
      1: return s[23:16];
      2: return s[15:8];
      3: return s[7:0];
      4: return 8'h02;
      5: return 8'h00;
      default: return 8'(idx);
    endcase
  endfunction

  task automatic expect_value(string tag, logic [47:0] obs, logic [47:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sampled at the falling edge: stability of stalled output, then content of
  // every accepted byte against the expected frame stream.
  task automatic checkOutput();
    logic [7:0] exp_byte;
    if (stall_prev) begin
      checks++;
      assert (m_eth_payload_axis_tvalid === 1'b1 && m_eth_payload_axis_tdata === held_data &&
              m_eth_payload_axis_tlast === held_last) else begin
        errors++;
        $error("[TB] FAIL stall_stable: observed v=%b d=%0h l=%b expected v=1 d=%0h l=%b",
               m_eth_payload_axis_tvalid, m_eth_payload_axis_tdata, m_eth_payload_axis_tlast,
               held_data, held_last);
      end
    end
    if (out_idx > 0 && !m_eth_payload_axis_tvalid) gaps++;
    if (m_eth_payload_axis_tvalid && m_eth_payload_axis_tready) begin
      exp_byte = (out_idx < HDR_LEN) ? hdr_exp(exp_seq, out_idx) : fifo_byte(pay_seen);
      checks++;
      assert (m_eth_payload_axis_tdata === exp_byte) else begin
        errors++;
        $error("[TB] FAIL byte[%0d] seq %0h: observed %0h expected %0h", out_idx, exp_seq,
               m_eth_payload_axis_tdata, exp_byte);
      end
      checks++;
      assert (m_eth_payload_axis_tlast === (out_idx == FRAME_LEN - 1)) else begin
        errors++;
        $error("[TB] FAIL tlast[%0d]: observed %b expected %b", out_idx,
               m_eth_payload_axis_tlast, (out_idx == FRAME_LEN - 1));
      end
      if (out_idx >= HDR_LEN) pay_seen++;
      if (out_idx == FRAME_LEN - 1) begin
        out_idx = 0;
        exp_seq = exp_seq + 32'd1;
        frames_seen++;
      end else begin
        out_idx++;
      end
    end
    stall_prev = m_eth_payload_axis_tvalid && !m_eth_payload_axis_tready;
    held_data  = m_eth_payload_axis_tdata;
    held_last  = m_eth_payload_axis_tlast;
  endtask

  // One clock cycle: check at the falling edge, then update the FIFO model and
  // the randomised handshakes just after the rising edge.
  task automatic applyStimulus();
    logic fifo_hs;
    @(negedge clk);
    fifo_hs = s_fifo_axis_tvalid && s_fifo_axis_tready;
    checkOutput();
    @(posedge clk);
    #1;
    if (fifo_hs) fifo_ptr++;
    s_fifo_axis_tdata         = fifo_byte(fifo_ptr);
    s_fifo_axis_tvalid        = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    m_eth_payload_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_until_frames(int target, int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      applyStimulus();
      n++;
    end
    expect_value("frames_done", 48'(frames_seen), 48'(target));
  endtask

  initial begin
    int ok;
    rst                       = 1'b1;
    enable                    = 1'b0;
    s_fifo_axis_tdata         = fifo_byte(0);
    s_fifo_axis_tvalid        = 1'b1;
    s_fifo_rd_data_count      = 11'd0;
    m_eth_hdr_ready           = 1'b1;
    m_eth_payload_axis_tready = 1'b1;
    repeat (3) applyStimulus();

    // Reset state and constant header fields.
    expect_value("rst_hdr_valid", 48'(m_eth_hdr_valid), 48'h0);
    expect_value("rst_tvalid", 48'(m_eth_payload_axis_tvalid), 48'h0);
    expect_value("rst_tlast", 48'(m_eth_payload_axis_tlast), 48'h0);
    expect_value("rst_tuser", 48'(m_eth_payload_axis_tuser), 48'h0);
    expect_value("rst_fifo_ready", 48'(s_fifo_axis_tready), 48'h0);
    expect_value("rst_busy", 48'(busy), 48'h0);
    expect_value("rst_frame_count", 48'(frame_count), 48'h0);
    expect_value("dest_mac", m_eth_dest_mac, 48'hD45D64A5F1A8);
    expect_value("src_mac", m_eth_src_mac, 48'h020000000000);
    expect_value("eth_type", 48'(m_eth_type), 48'h0800);
    rst = 1'b0;

    // One byte short of a payload: nothing may start for 100 cycles.
    $display("[TB] occupancy threshold");
    s_fifo_rd_data_count = 11'd511;
    enable = 1'b1;
    ok = 1;
    repeat (100) begin
      applyStimulus();
      if (m_eth_hdr_valid !== 1'b0 || s_fifo_axis_tready !== 1'b0) ok = 0;
    end
    expect_value("below_threshold_idle", 48'(ok), 48'h1);
    s_fifo_rd_data_count = 11'd512;
    applyStimulus();
    expect_value("start_hdr_valid", 48'(m_eth_hdr_valid), 48'h1);
    expect_value("start_busy", 48'(busy), 48'h1);
    enable = 1'b0;

    // Ideal downstream: 532 contiguous bytes, sequence 0.
    $display("[TB] ideal frame");
    gaps = 0;
    run_until_frames(1, 1000);
    expect_value("contiguous", 48'(gaps), 48'h0);
    repeat (2) applyStimulus();
    expect_value("fc_after_first", 48'(frame_count), 48'h1);
    expect_value("idle_busy", 48'(busy), 48'h0);
    expect_value("idle_hdr_valid", 48'(m_eth_hdr_valid), 48'h0);

    // Three back-to-back frames with random stalls on both sides.
    $display("[TB] back-to-back with random stalls");
    rnd_ready = 1'b1;
    rnd_valid = 1'b1;
    enable = 1'b1;
    run_until_frames(4, 12000);
    enable = 1'b0;
    rnd_ready = 1'b0;
    rnd_valid = 1'b0;
    repeat (3) applyStimulus();
    expect_value("fc_after_b2b", 48'(frame_count), 48'h4);
    expect_value("b2b_busy", 48'(busy), 48'h0);

    // Header handshake withheld: payload finishes, packer waits for it.
    $display("[TB] withheld header handshake");
    m_eth_hdr_ready = 1'b0;
    enable = 1'b1;
    applyStimulus();
    enable = 1'b0;
    repeat (600) applyStimulus();
    expect_value("wait_frames_out", 48'(frames_seen), 48'h5);
    expect_value("wait_busy", 48'(busy), 48'h1);
    expect_value("wait_hdr_valid", 48'(m_eth_hdr_valid), 48'h1);
    expect_value("wait_no_tvalid", 48'(m_eth_payload_axis_tvalid), 48'h0);
    m_eth_hdr_ready = 1'b1;
    applyStimulus();
    expect_value("wait_release_hdr", 48'(m_eth_hdr_valid), 48'h0);
    expect_value("wait_release_busy", 48'(busy), 48'h0);
    expect_value("wait_release_fc", 48'(frame_count), 48'h5);

    // Sequence number wrap.
    $display("[TB] sequence wrap");
    force dut.seq_num = 32'hFFFFFFFF;
    applyStimulus();
    release dut.seq_num;
    exp_seq = 32'hFFFFFFFF;
    enable = 1'b1;
    applyStimulus();
    enable = 1'b0;
    run_until_frames(6, 1000);
    repeat (2) applyStimulus();
    enable = 1'b1;
    applyStimulus();
    enable = 1'b0;
    run_until_frames(7, 1000);
    repeat (2) applyStimulus();
    expect_value("wrap_fc", 48'(frame_count), 48'h7);
    expect_value("wrap_next_seq", 48'(exp_seq), 48'h1);

    // Reset in the middle of the payload.
    $display("[TB] reset mid-payload");
    enable = 1'b1;
    applyStimulus();
    enable = 1'b0;
    ok = 0;
    while (out_idx < HDR_LEN + 100 && ok < 1000) begin
      applyStimulus();
      ok++;
    end
    expect_value("reached_byte_100", 48'(out_idx), 48'(HDR_LEN + 100));
    rst = 1'b1;
    applyStimulus();
    expect_value("mid_rst_tvalid", 48'(m_eth_payload_axis_tvalid), 48'h0);
    expect_value("mid_rst_tlast", 48'(m_eth_payload_axis_tlast), 48'h0);
    expect_value("mid_rst_hdr_valid", 48'(m_eth_hdr_valid), 48'h0);
    expect_value("mid_rst_fifo_ready", 48'(s_fifo_axis_tready), 48'h0);
    expect_value("mid_rst_busy", 48'(busy), 48'h0);
    expect_value("mid_rst_fc", 48'(frame_count), 48'h0);
    out_idx    = 0;
    exp_seq    = 32'h0;
    pay_seen   = fifo_ptr;
    stall_prev = 1'b0;
    rst = 1'b0;
    applyStimulus();
    expect_value("post_rst_tvalid", 48'(m_eth_payload_axis_tvalid), 48'h0);
    enable = 1'b1;
    applyStimulus();
    enable = 1'b0;
    run_until_frames(8, 1000);
    repeat (2) applyStimulus();
    expect_value("post_rst_fc", 48'(frame_count), 48'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
